// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package mdu_pkg;

   localparam int ITER_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX
   } state_e;

   // Two's-complement negate by invert-and-increment (kept off the shared adder).
   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   // Magnitude of a signed value; 0x8000_0000 maps to unsigned 0x8000_0000.
   function automatic logic [31:0] mag32(input logic [31:0] x);
      return x[31] ? neg32(x) : x;
   endfunction

endpackage

// File: rtl/mul_div_unit_adder.sv
// 32-bit ripple-carry adder shared by the multiply and divide iterations.
// Latency: purely combinational.
// Backpressure: none.
// Ports: operand1/operand2/cin in, sum/cout out.
module mul_div_unit_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = operand1[i] ^ operand2[i] ^ carry;
         carry  = (operand1[i] & operand2[i]) | (carry & (operand1[i] ^ operand2[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency: start sampled at edge E0 -> done pulse and HI/LO valid after E0+34.
// Backpressure: none; start and MTHI/MTLO writes are dropped while busy.
// Ports: clk, rst_n; start/op/rs_val/rt_val launch an operation; hi_we/lo_we/wdata
//        write HI/LO when idle; busy/done/div0 status; hi/lo architectural registers.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e                state_q;
   op_e                   op_q;
   logic [ITER_CNT_W-1:0] cnt_q;
   logic                  busy_q, done_q, div0_q;
   logic [WIDTH-1:0]      hi_q, lo_q;
   logic [WIDTH-1:0]      a_q, b_q;      // original operands, a_q kept for the div-by-zero HI
   logic [WIDTH-1:0]      acc_q;         // product high half / partial remainder
   logic [WIDTH-1:0]      mplr_q;        // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0]      opnd_q;        // multiplicand or divisor magnitude
   logic                  negq_q, negr_q, dz_q;

   // Operand preparation
   logic             is_div, is_signed;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Shared adder hookup
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout;
   logic [WIDTH-1:0] rem_sh;
   logic             msb_out;
   logic [WIDTH-1:0] run_acc_d, run_mplr_d;

   // Final fix-up
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign a_mag     = is_signed ? mag32(a_q) : a_q;
   assign b_mag     = is_signed ? mag32(b_q) : b_q;

   // Divide step works on the remainder shifted left by one, pulling in the next dividend bit.
   assign rem_sh  = {acc_q[WIDTH-2:0], mplr_q[WIDTH-1]};
   assign msb_out = acc_q[WIDTH-1];

   always_comb begin
      if (is_div) begin
         add_a   = rem_sh;
         add_b   = ~opnd_q;
         add_cin = 1'b1;
      end else begin
         add_a   = acc_q;
         add_b   = mplr_q[0] ? opnd_q : '0;
         add_cin = 1'b0;
      end
   end

   mul_div_unit_adder #(.WIDTH(WIDTH)) u_adder (
      .operand1 (add_a),
      .operand2 (add_b),
      .cin      (add_cin),
      .sum      (add_sum),
      .cout     (add_cout)
   );

   always_comb begin
      run_acc_d  = acc_q;
      run_mplr_d = mplr_q;
      if (is_div) begin
         // A bit shifted out of the remainder means it certainly exceeds the divisor.
         if (msb_out | add_cout) begin
            run_acc_d  = add_sum;
            run_mplr_d = {mplr_q[WIDTH-2:0], 1'b1};
         end else begin
            run_acc_d  = rem_sh;
            run_mplr_d = {mplr_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         run_acc_d  = {add_cout, add_sum[WIDTH-1:1]};
         run_mplr_d = {add_sum[0], mplr_q[WIDTH-1:1]};
      end
   end

   assign prod     = {acc_q, mplr_q};
   assign prod_fix = negq_q ? (~prod + 64'd1) : prod;

   always_comb begin
      fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_fix[WIDTH-1:0];
      if (dz_q) begin
         fix_hi_d = a_q;
         fix_lo_d = '1;
      end else if (is_div) begin
         fix_hi_d = negr_q ? neg32(acc_q) : acc_q;
         fix_lo_d = negq_q ? neg32(mplr_q) : mplr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         opnd_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         div0_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (start) begin
                  op_q    <= op_e'(op);
                  a_q     <= rs_val;
                  b_q     <= rt_val;
                  busy_q  <= 1'b1;
                  state_q <= ST_PREP;
               end
            end
            ST_PREP: begin
               acc_q <= '0;
               if (is_div) begin
                  mplr_q <= a_mag;
                  opnd_q <= b_mag;
               end else begin
                  mplr_q <= b_mag;
                  opnd_q <= a_mag;
               end
               negq_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               negr_q  <= is_signed & a_q[WIDTH-1];
               dz_q    <= is_div & (b_q == '0);
               cnt_q   <= ITER_CNT_W'(ITERS - 1);
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               acc_q  <= run_acc_d;
               mplr_q <= run_mplr_d;
               cnt_q  <= cnt_q - ITER_CNT_W'(1);
               if (cnt_q == '0) state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= fix_hi_d;
               lo_q    <= fix_lo_d;
               done_q  <= 1'b1;
               div0_q  <= dz_q;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
